// File: rtl/soc_pkg.sv
// soc_pkg: shared state encodings and flag-word values for the UART/RAM bridge
package soc_pkg;
  typedef enum logic [2:0] {IDLE, RX, SETF, POLL, GETLEN, TXRD, TXSH, CLRF} bridge_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  localparam logic [31:0] FLAG_IDLE  = 32'd0;
  localparam logic [31:0] FLAG_READY = 32'd1;
  localparam logic [31:0] FLAG_DONE  = 32'd2;
endpackage

// File: rtl/uart_ram_bridge_if.sv
// uart_ram_bridge_if: port-2 RAM bus between the bridge (master) and the dual-port RAM (slave)
interface uart_ram_bridge_if;
  logic [31:0] rramdata;
  logic        wram;
  logic [31:0] ramaddress;
  logic [31:0] wramdata;
  modport master(input rramdata, output wram, ramaddress, wramdata);
  modport slave(output rramdata, input wram, ramaddress, wramdata);
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: serial RX deserialiser with start-glitch rejection and stop-bit check
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       datai,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       stop_err
);
  import soc_pkg::*;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  rx_state_e st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic prev;
  assign byte_out = sh;
  // state register plus previous line level for falling-edge detection
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st   <= RX_IDLE;
      cnt  <= '0;
      idx  <= '0;
      sh   <= '0;
      prev <= 1'b1;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      idx  <= idx_n;
      sh   <= sh_n;
      prev <= datai;
    end
  end
  // framing: half-bit start check, eight mid-bit samples, then the stop bit
  always_comb begin
    st_n       = st;
    cnt_n      = cnt + 1'b1;
    idx_n      = idx;
    sh_n       = sh;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    case (st)
      RX_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        st_n  = (prev && !datai) ? RX_START : RX_IDLE;
      end
      RX_START: if (cnt == HALF_END) begin
        cnt_n = '0;
        st_n  = datai ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == BIT_END) begin
        cnt_n = '0;
        sh_n  = {datai, sh[7:1]};
        idx_n = idx + 3'd1;
        st_n  = (idx == 3'd7) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (cnt == BIT_END) begin
        st_n       = RX_IDLE;
        byte_valid = datai;
        stop_err   = !datai;
      end
      default: st_n = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_ram_bridge.sv
// uart_ram_bridge: serial image loader / JPEG result streamer on RAM port 2 with flag-word handoff
module uart_ram_bridge #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          RX_WORDS     = 1024,
  parameter logic [31:0] RX_BASE      = 32'h0000,
  parameter logic [31:0] FLAG_ADDR    = 32'h1000,
  parameter logic [31:0] LEN_ADDR     = 32'h1004,
  parameter logic [31:0] TX_BASE      = 32'h1008
) (
  input  logic clk,
  input  logic nrst,
  input  logic datai,
  output logic datao,
  output logic busy,
  output logic frame_err,
  uart_ram_bridge_if.master ram
);
  import soc_pkg::*;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int WIW = (RX_WORDS > 1) ? $clog2(RX_WORDS) : 1;
  localparam logic [CW-1:0]  BIT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [WIW-1:0] LAST_WORD = WIW'(RX_WORDS - 1);
  bridge_state_e st, st_n;
  logic [1:0] ph, ph_n, bcnt, bcnt_n, tbyte, tbyte_n;
  logic [WIW-1:0] widx, widx_n;
  logic [31:0] pbuf, pbuf_n, count, count_n, n, n_n, txw, txw_n;
  logic [CW-1:0] tcnt, tcnt_n;
  logic [3:0] tbit, tbit_n;
  logic wram_q, wram_n, datao_n;
  logic [31:0] addr_q, addr_n, wdata_q, wdata_n;
  logic [7:0] cur, rx_byte;
  logic rx_valid, rx_err;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .nrst(nrst), .datai(datai),
    .byte_out(rx_byte), .byte_valid(rx_valid), .stop_err(rx_err)
  );
  assign ram.wram       = wram_q;
  assign ram.ramaddress = addr_q;
  assign ram.wramdata   = wdata_q;
  assign busy           = st != IDLE;
  // every output is registered; frame_err latches any RX stop error
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st        <= IDLE;
      ph        <= '0;
      bcnt      <= '0;
      widx      <= '0;
      pbuf      <= '0;
      count     <= '0;
      n         <= '0;
      txw       <= '0;
      tcnt      <= '0;
      tbit      <= '0;
      tbyte     <= '0;
      wram_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      datao     <= 1'b1;
      frame_err <= 1'b0;
    end else begin
      st        <= st_n;
      ph        <= ph_n;
      bcnt      <= bcnt_n;
      widx      <= widx_n;
      pbuf      <= pbuf_n;
      count     <= count_n;
      n         <= n_n;
      txw       <= txw_n;
      tcnt      <= tcnt_n;
      tbit      <= tbit_n;
      tbyte     <= tbyte_n;
      wram_q    <= wram_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      datao     <= datao_n;
      frame_err <= frame_err | rx_err;
    end
  end
  // handoff FSM; reads take three phases: drive address, RAM latency, use rramdata
  always_comb begin
    st_n    = st;
    ph_n    = ph;
    bcnt_n  = bcnt;
    widx_n  = widx;
    pbuf_n  = pbuf;
    count_n = count;
    n_n     = n;
    txw_n   = txw;
    tcnt_n  = tcnt;
    tbit_n  = tbit;
    tbyte_n = tbyte;
    wram_n  = 1'b0;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    datao_n = 1'b1;
    cur     = 8'(txw >> {tbyte, 3'b000});
    case (st)
      IDLE, RX: if (rx_valid) begin
        st_n   = RX;
        pbuf_n = {rx_byte, pbuf[31:8]};
        bcnt_n = bcnt + 2'd1;
        if (bcnt == 2'd3) begin
          wram_n  = 1'b1;
          addr_n  = RX_BASE + (32'(widx) << 2);
          wdata_n = pbuf_n;
          widx_n  = (widx == LAST_WORD) ? '0 : widx + 1'b1;
          st_n    = (widx == LAST_WORD) ? SETF : RX;
        end
      end
      SETF: begin
        wram_n  = 1'b1;
        addr_n  = FLAG_ADDR;
        wdata_n = FLAG_READY;
        ph_n    = '0;
        st_n    = POLL;
      end
      POLL: begin
        addr_n = (ph == 2'd0) ? FLAG_ADDR : addr_q;
        ph_n   = (ph == 2'd2) ? 2'd0 : ph + 2'd1;
        st_n   = (ph == 2'd2 && ram.rramdata == FLAG_DONE) ? GETLEN : POLL;
      end
      GETLEN: begin
        addr_n = (ph == 2'd0) ? LEN_ADDR : addr_q;
        ph_n   = (ph == 2'd2) ? 2'd0 : ph + 2'd1;
        if (ph == 2'd2) begin
          count_n = ram.rramdata;
          n_n     = '0;
          st_n    = (ram.rramdata == 32'd0) ? CLRF : TXRD;
        end
      end
      TXRD: begin
        addr_n = (ph == 2'd0) ? TX_BASE + (n << 2) : addr_q;
        ph_n   = (ph == 2'd2) ? 2'd0 : ph + 2'd1;
        if (ph == 2'd2) begin
          txw_n   = ram.rramdata;
          tcnt_n  = '0;
          tbit_n  = '0;
          tbyte_n = '0;
          st_n    = TXSH;
        end
      end
      TXSH: begin
        datao_n = (tbit == 4'd0) ? 1'b0 : (tbit == 4'd9) ? 1'b1 : cur[3'(tbit - 4'd1)];
        tcnt_n  = tcnt + 1'b1;
        if (tcnt == BIT_END) begin
          tcnt_n  = '0;
          tbit_n  = (tbit == 4'd9) ? 4'd0 : tbit + 4'd1;
          tbyte_n = (tbit == 4'd9) ? tbyte + 2'd1 : tbyte;
          if (tbit == 4'd9 && tbyte == 2'd3) begin
            n_n  = n + 32'd1;
            st_n = (n + 32'd1 < count) ? TXRD : CLRF;
          end
        end
      end
      CLRF: begin
        wram_n  = 1'b1;
        addr_n  = FLAG_ADDR;
        wdata_n = FLAG_IDLE;
        st_n    = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end
endmodule
